// File: rtl/sequential_divider.sv
// Radix-2 restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// Results are held in dedicated output registers so they stay stable while the next division runs.
module sequential_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quot,
    output logic [7:0]  rem,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_dvd;
    logic [7:0]  r_dsr;
    logic [8:0]  r_prem;
    logic [4:0]  r_cnt;
    logic [15:0] r_quot;
    logic [7:0]  r_rem;
    logic        r_dbz;

    logic [8:0]  w_shift;
    logic [8:0]  w_prem_next;
    logic        w_qbit;
    logic        w_last;
    logic        w_accept;

    // r_prem[8] set would mean the shifted value exceeds any 8-bit divisor.
    always_comb begin
        w_shift     = {r_prem[7:0], r_dvd[15]};
        w_qbit      = r_prem[8] | (w_shift >= {1'b0, r_dsr});
        w_prem_next = w_qbit ? (w_shift - {1'b0, r_dsr}) : w_shift;
        w_last      = (r_cnt == 5'd15);
        w_accept    = start && (r_state != StRun);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_next = (divisor == 8'd0) ? StDone : StRun;
            StRun:  if (w_last) w_state_next = StDone;
            StDone: begin
                if (start) w_state_next = (divisor == 8'd0) ? StDone : StRun;
                else       w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_dvd  <= dividend;
            r_dsr  <= divisor;
            r_prem <= '0;
            r_cnt  <= '0;
            if (divisor == 8'd0) begin
                r_quot <= 16'hFFFF;
                r_rem  <= 8'hFF;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == StRun) begin
            r_dvd  <= {r_dvd[14:0], w_qbit};
            r_prem <= w_prem_next;
            r_cnt  <= r_cnt + 5'd1;
            if (w_last) begin
                r_quot <= {r_dvd[14:0], w_qbit};
                r_rem  <= w_prem_next[7:0];
                r_dbz  <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == StRun);
    assign done        = (r_state == StDone);
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have no parameters; widths are fixed at 16-bit dividend and 8-bit divisor, the inverse of the 8x8 unsigned multiplier.
REQ-002 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled on rising clk.
REQ-005 SHALL have port dividend, input, 16 [16:1], unsigned numerator, bit 1 = LSB.
REQ-006 SHALL have port divisor, input, 8 [8:1], unsigned denominator, bit 1 = LSB.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 SHALL have port quot, output, 16 [16:1], quotient.
REQ-010 SHALL have port rem, output, 8 [8:1], remainder.
REQ-011 SHALL have port div_by_zero, output, 1, flag qualifying the current quot/rem.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE or DONE with start=1 at edge T0, capture dividend and divisor, clear the 5-bit iteration counter and the 9-bit partial remainder, and enter RUN (divisor != 0) or DONE (divisor == 0).
REQ-014 SHALL use radix-2 restoring division in RUN, one quotient bit per edge, MSB first: shift partial remainder left, bringing in the next dividend bit; subtract divisor if the result is >= divisor; the quotient bit is 1 if subtracted, else 0.
REQ-015 SHALL perform the 16 iterations on edges T1..T16, and on T16 register quot/rem, set div_by_zero=0 and enter DONE.
REQ-016 SHALL assert done only in DONE, exactly one cycle; DONE returns to IDLE on the next edge unless start=1.
REQ-017 SHALL assert busy only in RUN; busy and done are never high together.
REQ-018 SHALL ignore start while busy=1; captured operands are unaffected by input changes after T0.
REQ-019 SHALL accept start during the DONE cycle (back-to-back operation): done still pulses once, and the next division begins.
REQ-020 SHALL, when divisor == 0, enter DONE at T0, then pulse done in the following cycle with quot=16'hFFFF, rem=8'hFF and div_by_zero=1.
REQ-021 SHALL hold quot, rem and div_by_zero stable from done until the next completion; they do not change during RUN.
REQ-022 SHALL guarantee rem < divisor and quot*divisor + rem == dividend for every divisor != 0; the partial remainder never exceeds 9 bits.
REQ-023 SHALL use a latency of 17 cycles from the start edge to the done cycle (divisor != 0), and 1 cycle for divisor == 0.

Reset
REQ-024 SHALL, while rst_n=0, immediately force the state to IDLE and busy=0, done=0, quot=0, rem=0, div_by_zero=0, counter=0, partial remainder=0, independent of clk.
REQ-025 SHALL, when rst_n asserts mid-RUN, abandon the division with no done pulse; after release the block is idle and accepts start on the first active edge.

Verification
REQ-026 SHALL cover: dividend=50000, divisor=200 -> done 17 cycles after start, quot=250, rem=0, div_by_zero=0.
REQ-027 SHALL cover: 1000/7 -> quot=142, rem=6; 65535/1 -> quot=16'hFFFF, rem=0; 255/255 -> quot=1, rem=0; 0/9 -> quot=0, rem=0.
REQ-028 SHALL cover: divisor=0, dividend=1234 -> done one cycle after the start edge, quot=16'hFFFF, rem=8'hFF, div_by_zero=1; a following 12/5 clears the flag and gives quot=2, rem=2.
REQ-029 SHALL cover: start re-pulsed with new operands at cycle 5 of RUN -> ignored, first result unchanged; start held during the done cycle -> second division completes 17 cycles later.
REQ-030 SHALL cover: rst_n low at cycle 8 of RUN -> outputs zero asynchronously, no done; the next division after release is correct.
REQ-031 SHALL cover a round-trip test of 10000 random A,B with B != 0: divide the 8x8 multiplier product by B -> quot=A, rem=0; also random dividend/divisor checked against the reference model.
